// File: rtl/stack_arbiter.sv
// Purpose: round-robin arbiter granting two requesters push/pop access to one stack.
// Latency: request seen in IDLE at cycle N, stack strobe in N+1, ack in N+2 (one op per 3 cycles).
// Backpressure: requesters hold req/op/din until ack; a full or empty stack rejects with err, never stalls.
module stack_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             op_a,
    input  logic             op_b,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             err,
    output logic [WIDTH-1:0] dout,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_value_in,
    input  logic [WIDTH-1:0] stk_value_out,
    input  logic             stk_full,
    input  logic             stk_empty,
    output logic [3:0]       level
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LEVEL_MAX = 4'd8;

    state_t           state_q, state_d;
    logic             win_b_q, win_b_d;    // latched winner: 1 = requester B
    logic             op_q, op_d;          // latched op: 1 = push
    logic [WIDTH-1:0] din_q, din_d;
    logic             pref_b_q, pref_b_d;  // requester favoured on a tie
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [3:0]       level_q, level_d;

    logic             push_ok;
    logic             pop_ok;
    logic             pick_b;

    // Strobes depend on the live stack flags during ISSUE, so they drop with state on reset.
    assign push_ok      = (state_q == ISSUE) &&  op_q && !stk_full;
    assign pop_ok       = (state_q == ISSUE) && !op_q && !stk_empty;
    assign stk_push     = push_ok;
    assign stk_pop      = pop_ok;
    assign stk_value_in = push_ok ? din_q : '0;

    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign err   = err_q;
    assign dout  = dout_q;
    assign level = level_q;

    // Next-state: arbitrate in IDLE, resolve the stack operation in ISSUE, ack and rotate in RESP.
    always_comb begin
        state_d  = state_q;
        win_b_d  = win_b_q;
        op_d     = op_q;
        din_d    = din_q;
        pref_b_d = pref_b_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        err_d    = err_q;
        dout_d   = dout_q;
        level_d  = level_q;
        pick_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    pick_b  = req_b && (!req_a || pref_b_q);
                    win_b_d = pick_b;
                    op_d    = pick_b ? op_b : op_a;
                    din_d   = pick_b ? din_b : din_a;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
                ack_a_d = !win_b_q;
                ack_b_d = win_b_q;
                if (push_ok) begin
                    err_d = 1'b0;
                    if (level_q != LEVEL_MAX) level_d = level_q + 4'd1;
                end else if (pop_ok) begin
                    err_d  = 1'b0;
                    dout_d = stk_value_out;
                    if (level_q != 4'd0) level_d = level_q - 4'd1;
                end else begin
                    err_d  = 1'b1;
                    dout_d = '0;
                end
            end
            RESP: begin
                state_d  = IDLE;
                pref_b_d = !win_b_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation and re-prefers A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            win_b_q  <= 1'b0;
            op_q     <= 1'b0;
            din_q    <= '0;
            pref_b_q <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
            level_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            op_q     <= op_d;
            din_q    <= din_d;
            pref_b_q <= pref_b_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    logic        clk;
    logic        reset;
    logic        req_a, req_b, op_a, op_b;
    logic [15:0] din_a, din_b;
    logic        ack_a, ack_b, err;
    logic [15:0] dout;
    logic        stk_push, stk_pop;
    logic [15:0] stk_value_in, stk_value_out;
    logic        stk_full, stk_empty;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    stack_arbiter #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_a        (req_a),
        .req_b        (req_b),
        .op_a         (op_a),
        .op_b         (op_b),
        .din_a        (din_a),
        .din_b        (din_b),
        .ack_a        (ack_a),
        .ack_b        (ack_b),
        .err          (err),
        .dout         (dout),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_value_in (stk_value_in),
        .stk_value_out(stk_value_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ra, oa;
        logic [15:0] da;
        logic        rb, ob;
        logic [15:0] db;
        logic        full, empty;
        logic [15:0] top;
        logic        e_b;       // expected winner is B
        logic        e_push, e_pop;
        logic [15:0] e_vin;
        logic        e_err;
        logic        chk_dout;
        logic [15:0] e_dout;
        logic [3:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ra, input logic oa, input logic [15:0] da,
                                input logic rb, input logic ob, input logic [15:0] db,
                                input logic full, input logic empty, input logic [15:0] top,
                                input logic e_b, input logic e_push, input logic e_pop,
                                input logic [15:0] e_vin, input logic e_err,
                                input logic chk_dout, input logic [15:0] e_dout,
                                input logic [3:0] e_lvl);
        vec_t v;
        v.ra = ra; v.oa = oa; v.da = da; v.rb = rb; v.ob = ob; v.db = db;
        v.full = full; v.empty = empty; v.top = top;
        v.e_b = e_b; v.e_push = e_push; v.e_pop = e_pop; v.e_vin = e_vin;
        v.e_err = e_err; v.chk_dout = chk_dout; v.e_dout = e_dout; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic idle_inputs();
        req_a = 0; req_b = 0; op_a = 0; op_b = 0; din_a = 0; din_b = 0;
        stk_full = 0; stk_empty = 1; stk_value_out = 0;
    endtask

    // Drive one vector from an IDLE negedge and check ISSUE, RESP and the following IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        req_a = v.ra; op_a = v.oa; din_a = v.da;
        req_b = v.rb; op_b = v.ob; din_b = v.db;
        stk_full = v.full; stk_empty = v.empty; stk_value_out = v.top;
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d stk_push", idx), stk_push, v.e_push);
        chk($sformatf("v%0d stk_pop", idx), stk_pop, v.e_pop);
        chk($sformatf("v%0d stk_value_in", idx), stk_value_in, v.e_vin);
        chk($sformatf("v%0d ack_in_issue", idx), {ack_a, ack_b}, 2'b00);
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d ack_a", idx), ack_a, !v.e_b);
        chk($sformatf("v%0d ack_b", idx), ack_b, v.e_b);
        chk($sformatf("v%0d err", idx), err, v.e_err);
        if (v.chk_dout) chk($sformatf("v%0d dout", idx), dout, v.e_dout);
        chk($sformatf("v%0d level", idx), level, v.e_lvl);
        chk($sformatf("v%0d strobes_in_resp", idx), {stk_push, stk_pop}, 2'b00);
        idle_inputs();
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d ack_after", idx), {ack_a, ack_b}, 2'b00);
        chk($sformatf("v%0d err_held", idx), err, v.e_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ra oa da      rb ob db      full empty top   e_b push pop vin     err chkd dout    lvl
        vecs.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0,    0, 1, 16'h0,    0, 1, 0, 16'h1234, 0, 0, 16'h0,    4'd1));
        vecs.push_back(mk(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 16'h1234, 1, 0, 1, 16'h0,    0, 1, 16'h1234, 4'd0));
        vecs.push_back(mk(1, 0, 16'h0,    0, 0, 16'h0,    0, 1, 16'hdead, 0, 0, 0, 16'h0,    1, 1, 16'h0,    4'd0));
        vecs.push_back(mk(1, 0, 16'h0,    1, 1, 16'h5555, 0, 1, 16'h0,    1, 1, 0, 16'h5555, 0, 0, 16'h0,    4'd1));
        vecs.push_back(mk(1, 1, 16'h1111, 1, 1, 16'h2222, 0, 0, 16'h0,    0, 1, 0, 16'h1111, 0, 0, 16'h0,    4'd2));
        vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0003, 0, 0, 16'h0,    1, 1, 0, 16'h0003, 0, 0, 16'h0,    4'd3));
        vecs.push_back(mk(1, 1, 16'h0004, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0004, 0, 0, 16'h0,    4'd4));
        vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0005, 0, 0, 16'h0,    1, 1, 0, 16'h0005, 0, 0, 16'h0,    4'd5));
        vecs.push_back(mk(1, 1, 16'h0006, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0006, 0, 0, 16'h0,    4'd6));
        vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0007, 0, 0, 16'h0,    1, 1, 0, 16'h0007, 0, 0, 16'h0,    4'd7));
        vecs.push_back(mk(1, 1, 16'h0008, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0008, 0, 0, 16'h0,    4'd8));
        vecs.push_back(mk(0, 0, 16'h0,    1, 1, 16'h0009, 1, 0, 16'h0,    1, 0, 0, 16'h0,    1, 0, 16'h0,    4'd8));
        vecs.push_back(mk(1, 1, 16'h000a, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h000a, 0, 0, 16'h0,    4'd8));
        vecs.push_back(mk(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 16'habcd, 1, 0, 1, 16'h0,    0, 1, 16'habcd, 4'd7));
        vecs.push_back(mk(1, 0, 16'h0,    0, 0, 16'h0,    0, 1, 16'h7777, 0, 0, 0, 16'h0,    1, 1, 16'h0,    4'd7));

        // Reset values, checked before any clock edge.
        idle_inputs();
        reset = 1'b0;
        #2;
        chk("reset ack", {ack_a, ack_b}, 2'b00);
        chk("reset err", err, 1'b0);
        chk("reset dout", dout, 16'h0);
        chk("reset strobes", {stk_push, stk_pop}, 2'b00);
        chk("reset stk_value_in", stk_value_in, 16'h0);
        chk("reset level", level, 4'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset pulse while stk_push is high: strobe drops at once, no ack, level cleared.
        req_a = 1; op_a = 1; din_a = 16'hbeef; stk_full = 0; stk_empty = 0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid push_before", stk_push, 1'b1);
        chk("rst_mid vin_before", stk_value_in, 16'hbeef);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid push_dropped", stk_push, 1'b0);
        chk("rst_mid vin_zero", stk_value_in, 16'h0);
        chk("rst_mid level", level, 4'd0);
        chk("rst_mid err", err, 1'b0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid no_ack c%0d", k), {ack_a, ack_b}, 2'b00);
            chk($sformatf("rst_mid no_strobe c%0d", k), {stk_push, stk_pop}, 2'b00);
        end

        // Both requesters held high: grants A,B,A,B with acks three cycles apart, A first after reset.
        req_a = 1; op_a = 1; din_a = 16'h00a0;
        req_b = 1; op_b = 1; din_b = 16'h00b0;
        stk_full = 0; stk_empty = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("rr ack_a k%0d", k), ack_a, (k == 2 || k == 8));
            chk($sformatf("rr ack_b k%0d", k), ack_b, (k == 5 || k == 11));
            chk($sformatf("rr push k%0d", k), stk_push, (k % 3 == 1));
            if (k % 3 == 1)
                chk($sformatf("rr vin k%0d", k), stk_value_in, (k % 6 == 1) ? 16'h00a0 : 16'h00b0);
        end
        chk("rr level", level, 4'd4);
        idle_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of requester and stack data ports.
REQ-002 SHALL have ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_a, req_b  input  1 each  operation request from requester A / B.
REQ-005 SHALL have ports: op_a, op_b  input  1 each  1 = push, 0 = pop.
REQ-006 SHALL have ports: din_a, din_b  input  WIDTH each  push data.
REQ-007 SHALL have ports: ack_a, ack_b  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have ports: err  output  1  valid with ack_x; 1 = operation rejected.
REQ-009 SHALL have ports: dout  output  WIDTH  pop data, valid with ack_x.
REQ-010 SHALL have ports: stk_push, stk_pop  output  1 each  one-cycle strobes to the stack.
REQ-011 SHALL have ports: stk_value_in  output  WIDTH  push data to the stack.
REQ-012 SHALL have ports: stk_value_out  input  WIDTH  stack top-of-stack data, combinational.
REQ-013 SHALL have ports: stk_full, stk_empty  input  1 each  stack status flags.
REQ-014 SHALL have ports: level  output  4  accepted pushes minus accepted pops, 0..8.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
REQ-016 IDLE -> ISSUE when req_a or req_b is high; winner, its op and its din are latched on that edge.
REQ-017 IDLE with no request SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- Only one requester high: that requester wins.
- Both high: the requester not granted last wins.
- After reset: A is preferred.
REQ-019 In ISSUE, latched push with stk_full=0: stk_push=1 for exactly that cycle, stk_value_in = latched din.
REQ-020 In ISSUE, latched pop with stk_empty=0: stk_pop=1 for exactly that cycle; stk_value_out captured into dout at the closing edge.
REQ-021 In ISSUE, push with stk_full=1 or pop with stk_empty=1:
- no stack strobe;
- err latched to 1;
- dout latched to 0.
REQ-022 ISSUE SHALL always go to RESP after one cycle.
REQ-023 In RESP:
- the winner's ack is high for one cycle, with err and dout valid;
- the round-robin pointer updates;
- FSM -> IDLE.
REQ-024 Latency SHALL be fixed: request seen in IDLE at cycle N, stack strobe in cycle N+1, ack in cycle N+2; peak throughput is one operation per 3 cycles.
REQ-025 Requesters SHALL hold req, op and din stable until ack and deassert req on the edge that samples ack; a req still high in the following IDLE counts as a new request.
REQ-026 ack_a and ack_b SHALL never be high together; stk_push and stk_pop SHALL never be high together.
REQ-027 Strobes SHALL be low outside ISSUE; stk_value_in SHALL be 0 when stk_push=0.
REQ-028 level SHALL:
- increment on each accepted push;
- decrement on each accepted pop;
- be unchanged on a rejected operation;
- never wrap.
REQ-029 err and dout SHALL hold their values until the next ISSUE.

Reset
REQ-030 reset=0 SHALL immediately, without clk, force:
- FSM to IDLE;
- ack_a, ack_b, err, stk_push, stk_pop to 0;
- dout, stk_value_in, level to 0;
- round-robin pointer to prefer A.
REQ-031 Reset asserted during ISSUE or RESP SHALL abort the operation without ack; strobes drop asynchronously.
REQ-032 After reset release, the first edge with a request SHALL be treated as IDLE.

Verification
REQ-033 Reset, stack empty, req_a=1, op_a=1, din_a=16'h1234 -> stk_push=1 with stk_value_in=16'h1234 in cycle 2, ack_a=1 and err=0 in cycle 3, level=1.
REQ-034 Stack top=16'h1234, req_b=1, op_b=0 -> stk_pop=1 in cycle 2, ack_b=1 with dout=16'h1234 and err=0 in cycle 3, level=0.
REQ-035 stk_empty=1, pop request from A -> no strobe, ack_a=1, err=1, dout=0, level unchanged.
REQ-036 stk_full=1, push request from B -> no strobe, ack_b=1, err=1, level unchanged at 8.
REQ-037 req_a and req_b held high continuously -> grant order A, B, A, B; acks 3 cycles apart; never simultaneous.
REQ-038 reset pulsed low while stk_push=1 -> stk_push drops immediately, no ack, FSM in IDLE, level=0.
